nn_selftest_sequencer: RTL and testbench
========================================

// Module: nn_selftest_sequencer
// PURPOSE
//  On-chip, parametrised replacement for the hand-driven KEY-pulse bench stimulus.
//  Sits between the board controls and the NN inference core.
//  For each of NUM_VECTORS stored test images, it:
//   - pulses the core's active-low start/reset line;
//   - waits for inference done;
//   - serially scans the NUM_CLASSES probability outputs for the argmax;
//   - compares the argmax against the expected label and accumulates pass/fail counts.
//  Results drive HEX/LEDR directly, so the board self-checks without a simulator.
// PARAMETERS
//  NUM_CLASSES     10     number of probability channels scanned
//  PROB_W          16     width of each probability word (unsigned)
//  NUM_VECTORS     8      number of stored test vectors run per start
//  PULSE_CYCLES    20     cycles core_key_n is held low per vector (>=1)
//  TIMEOUT_CYCLES  65535  max cycles to wait for core_done before a vector is failed
//  IDX_W           $clog2(NUM_CLASSES)  class index width (derived)
//  VEC_W           $clog2(NUM_VECTORS)  vector index width (derived)
// PORTS
//  Clk          in   1                      system clock
//  Reset        in   1                      asynchronous, active-high reset
//  start        in   1                      1-cycle pulse; begins a run (ignored while busy)
//  vec_idx      out  VEC_W                  address of current vector (to image/label ROM)
//  vec_label    in   IDX_W                  expected class of vec_idx; valid 1 cycle after vec_idx changes
//  core_key_n   out  1                      active-low start pulse to NN core (KEY[0] equivalent)
//  core_done    in   1                      level-high from core when Probability is stable
//  prob         in   NUM_CLASSES x PROB_W   core probability outputs
//  busy         out  1                      high from accepted start until done
//  done         out  1                      1-cycle pulse when the last vector completes
//  pass_count   out  VEC_W+1                vectors whose argmax matched the label
//  fail_count   out  VEC_W+1                vectors mismatched or timed out
//  last_argmax  out  IDX_W                  argmax of the most recent vector
//  timeout_err  out  1                      sticky; set if any vector timed out
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, except core_key_n=1;
//   - FSM goes to IDLE; in-flight work is abandoned.
//  States: IDLE -> PULSE -> WAIT -> SCAN -> CHECK -> (PULSE | FIN) -> IDLE.
//  IDLE:
//   - on start: clear pass/fail/timeout_err, vec_idx=0, busy=1, go to PULSE.
//  PULSE:
//   - core_key_n=0 for exactly PULSE_CYCLES cycles;
//   - then core_key_n=1 and go to WAIT.
//  WAIT:
//   - core_done sampled high -> go to SCAN;
//   - timer reaches TIMEOUT_CYCLES first -> fail_count++, timeout_err=1, go to next vector (SCAN skipped);
//   - core_done high on the same cycle as the timeout: done wins.
//  SCAN:
//   - one class per cycle, k=0..NUM_CLASSES-1; NUM_CLASSES cycles total;
//   - running max starts at prob[0] with idx 0;
//   - update only on strict '>', so ties resolve to the lowest index;
//   - comparison is unsigned, full PROB_W, no truncation.
//  CHECK (1 cycle):
//   - last_argmax <= idx;
//   - match with vec_label -> pass_count++, else fail_count++.
//  Advance:
//   - vec_idx == NUM_VECTORS-1 -> go to FIN;
//   - else vec_idx++ and go to PULSE.
//  FIN: done=1 for one cycle, busy=0, go to IDLE; counts hold until the next start.
//  start during busy is ignored.
//  Invariant: pass_count+fail_count == vectors completed.
//  Latency per vector, no timeout: PULSE_CYCLES + wait + NUM_CLASSES + 2 cycles.
// STRUCTURE
//  Shared package nn_pkg:
//   - NUM_CLASSES, PROB_W and prob_t = logic [PROB_W-1:0];
//   - selftest state enum st_state_e.
//  Sub-module argmax_serial (NUM_CLASSES, PROB_W):
//   - ports: start, prob array; outputs idx, max, valid;
//   - owns the SCAN counter and comparator.
//  Remainder: FSM, pulse/timeout counter (shared, width of max(PULSE,TIMEOUT)), vector counter.
// TESTING
//  1 Reset mid-PULSE -> core_key_n returns to 1 same cycle; busy=0, counts=0.
//  2 NUM_VECTORS=4; core_done 30 cycles after pulse; prob argmax equals label on all 4
//    -> pass=4, fail=0, done pulses once.
//  3 prob = {5,9,9,2,...} with label=1 -> argmax=1 (tie to lowest); label=2 -> fail.
//  4 core_done never asserted, TIMEOUT_CYCLES=100
//    -> each vector fails at cycle 100 after pulse; timeout_err=1.
//  5 core_key_n low exactly PULSE_CYCLES=20 cycles per vector; start pulsed while busy -> no effect.
//  6 prob[9]=16'hFFFF, others 16'h7FFF -> argmax=9 (unsigned full-width compare).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and default sizing for the NN inference core and its self-test sequencer.
package nn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned PROB_W      = 16;

    typedef logic [PROB_W-1:0] prob_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT,
        ST_SCAN,
        ST_CHECK,
        ST_FIN
    } st_state_e;

endpackage

// File: rtl/argmax_serial.sv
// Serial argmax over NUM_CLASSES unsigned probability words, one class per cycle.
// Ties keep the lowest index; valid pulses for one cycle when idx/max are final.
module argmax_serial #(
    parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int unsigned PROB_W      = nn_pkg::PROB_W,
    parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CLASSES*PROB_W-1:0] prob,
    output logic [IDX_W-1:0]              idx,
    output logic [PROB_W-1:0]             max,
    output logic                          valid
);

    logic [PROB_W-1:0] word [NUM_CLASSES];
    logic [IDX_W-1:0]  k_q;
    logic              running_q;

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_word
        assign word[i] = prob[i*PROB_W +: PROB_W];
    end

    // start seeds the running max with class 0; later classes replace it only when strictly larger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            max       <= '0;
            valid     <= 1'b0;
            k_q       <= '0;
            running_q <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                max       <= word[0];
                idx       <= '0;
                k_q       <= IDX_W'(1);
                running_q <= (NUM_CLASSES > 1);
                valid     <= (NUM_CLASSES == 1);
            end else if (running_q) begin
                if (word[k_q] > max) begin
                    max <= word[k_q];
                    idx <= k_q;
                end
                if (k_q == IDX_W'(NUM_CLASSES - 1)) begin
                    running_q <= 1'b0;
                    valid     <= 1'b1;
                end
                k_q <= k_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/nn_selftest_sequencer.sv
// On-chip self-test: pulses the NN core per stored vector, scans its argmax and
// tallies label matches, so the board can report pass/fail without a simulator.
module nn_selftest_sequencer #(
    parameter int unsigned NUM_CLASSES    = nn_pkg::NUM_CLASSES,
    parameter int unsigned PROB_W         = nn_pkg::PROB_W,
    parameter int unsigned NUM_VECTORS    = 8,
    parameter int unsigned PULSE_CYCLES   = 20,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned IDX_W          = $clog2(NUM_CLASSES),
    parameter int unsigned VEC_W          = $clog2(NUM_VECTORS)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    output logic [VEC_W-1:0]              vec_idx,
    input  logic [IDX_W-1:0]              vec_label,
    output logic                          core_key_n,
    input  logic                          core_done,
    input  logic [NUM_CLASSES*PROB_W-1:0] prob,
    output logic                          busy,
    output logic                          done,
    output logic [VEC_W:0]                pass_count,
    output logic [VEC_W:0]                fail_count,
    output logic [IDX_W-1:0]              last_argmax,
    output logic                          timeout_err
);

    import nn_pkg::*;

    localparam int unsigned CNT_W   = VEC_W + 1;
    localparam int unsigned TMR_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    st_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [VEC_W-1:0] vec_idx_d;
    logic [CNT_W-1:0] pass_d, fail_d;
    logic [IDX_W-1:0] argmax_d;
    logic             key_d, busy_d, done_d, terr_d;
    logic             advance_c;
    logic             scan_start_c;
    logic             scan_valid;
    logic [IDX_W-1:0] scan_idx;
    logic [PROB_W-1:0] scan_max_unused;

    argmax_serial #(
        .NUM_CLASSES(NUM_CLASSES),
        .PROB_W     (PROB_W),
        .IDX_W      (IDX_W)
    ) u_argmax (
        .clk  (Clk),
        .rst  (Reset),
        .start(scan_start_c),
        .prob (prob),
        .idx  (scan_idx),
        .max  (scan_max_unused),
        .valid(scan_valid)
    );

    // Next-state and next-output logic; the timer is shared by PULSE, WAIT and SCAN entry
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        vec_idx_d    = vec_idx;
        key_d        = core_key_n;
        busy_d       = busy;
        done_d       = 1'b0;
        pass_d       = pass_count;
        fail_d       = fail_count;
        argmax_d     = last_argmax;
        terr_d       = timeout_err;
        advance_c    = 1'b0;
        scan_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d    = '0;
                    fail_d    = '0;
                    terr_d    = 1'b0;
                    vec_idx_d = '0;
                    busy_d    = 1'b1;
                    key_d     = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_q == TMR_W'(PULSE_CYCLES - 1)) begin
                    key_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    timer_d = '0;
                    state_d = ST_SCAN;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    fail_d    = fail_count + CNT_W'(1);
                    terr_d    = 1'b1;
                    advance_c = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SCAN: begin
                scan_start_c = (timer_q == '0);
                timer_d      = TMR_W'(1);
                if (scan_valid) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                argmax_d = scan_idx;
                if (scan_idx == vec_label) begin
                    pass_d = pass_count + CNT_W'(1);
                end else begin
                    fail_d = fail_count + CNT_W'(1);
                end
                advance_c = 1'b1;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance_c) begin
            if (vec_idx == VEC_W'(NUM_VECTORS - 1)) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_FIN;
            end else begin
                vec_idx_d = vec_idx + VEC_W'(1);
                key_d     = 1'b0;
                timer_d   = '0;
                state_d   = ST_PULSE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            vec_idx     <= '0;
            core_key_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            last_argmax <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            vec_idx     <= vec_idx_d;
            core_key_n  <= key_d;
            busy        <= busy_d;
            done        <= done_d;
            pass_count  <= pass_d;
            fail_count  <= fail_d;
            last_argmax <= argmax_d;
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_nn_selftest_sequencer.sv
// Bench for nn_selftest_sequencer: emulated core/ROM, timeline model of every
// vector run, per-cycle comparison of all outputs, directed and random runs.
module tb_nn_selftest_sequencer;

    localparam int NC = 10;
    localparam int PW = 16;
    localparam int NV = 4;
    localparam int P  = 20;
    localparam int T  = 100;
    localparam int IW = 4;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [VW-1:0]     vec_idx;
    logic [IW-1:0]     vec_label = '0;
    logic              core_key_n;
    logic              core_done = 1'b0;
    logic [NC*PW-1:0]  prob;
    logic              busy;
    logic              done;
    logic [VW:0]       pass_count;
    logic [VW:0]       fail_count;
    logic [IW-1:0]     last_argmax;
    logic              timeout_err;

    nn_selftest_sequencer #(
        .NUM_CLASSES   (NC),
        .PROB_W        (PW),
        .NUM_VECTORS   (NV),
        .PULSE_CYCLES  (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .start      (start),
        .vec_idx    (vec_idx),
        .vec_label  (vec_label),
        .core_key_n (core_key_n),
        .core_done  (core_done),
        .prob       (prob),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .last_argmax(last_argmax),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Emulated image/label ROM and core behaviour
    logic [PW-1:0] prob_rom [NV][NC];
    int            label_rom [NV];
    int            delay [NV];
    int            core_cnt = 0;

    always_comb begin
        prob = '0;
        for (int k = 0; k < NC; k++) prob[k*PW +: PW] = prob_rom[vec_idx][k];
    end

    always_ff @(posedge clk) vec_label <= IW'(label_rom[vec_idx]);

    always @(negedge clk) begin
        if (busy && core_key_n) begin
            core_cnt  = core_cnt + 1;
            core_done = (core_cnt >= delay[vec_idx]);
        end else begin
            core_cnt  = 0;
            core_done = 1'b0;
        end
    end

    // Checking bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model of one run: where each vector sits on the timeline and how it ends
    int off [NV];
    int len [NV];
    int am  [NV];
    bit is_pass [NV];
    bit is_tmo  [NV];
    int total      = 0;
    int s_cyc      = 0;
    int prev_last  = 0;
    int done_seen  = 0;
    bit run_active = 1'b0;
    bit check_en   = 1'b0;

    function automatic int model_argmax(input int v);
        int best = 0;
        for (int k = 1; k < NC; k++)
            if (prob_rom[v][k] > prob_rom[v][best]) best = k;
        return best;
    endfunction

    task automatic plan_run();
        int o = 0;
        for (int j = 0; j < NV; j++) begin
            is_tmo[j]  = (delay[j] > T);
            am[j]      = model_argmax(j);
            is_pass[j] = !is_tmo[j] && (am[j] == label_rom[j]);
            len[j]     = is_tmo[j] ? (P + T) : (P + delay[j] + NC + 2);
            off[j]     = o;
            o          = o + len[j];
        end
        total = o;
    endtask

    int r, ek, eb, ed, ev, ep, ef, et, el;
    always @(negedge clk) begin
        if (check_en) begin
            ek = 1; eb = 0; ed = 0; ev = -1;
            r  = cyc - s_cyc;
            if (run_active && r >= 0) begin
                ep = 0; ef = 0; et = 0; el = prev_last;
                for (int j = 0; j < NV; j++) begin
                    if (r >= off[j] && r < off[j] + len[j]) begin
                        eb = 1;
                        ev = j;
                        ek = (r - off[j] < P) ? 0 : 1;
                    end
                    if (r >= off[j] + len[j]) begin
                        if (is_pass[j]) ep++; else ef++;
                        if (is_tmo[j]) et = 1; else el = am[j];
                    end
                end
                if (r == total) ed = 1;
                chk("pass_count", 32'(pass_count), ep);
                chk("fail_count", 32'(fail_count), ef);
                chk("timeout_err", 32'(timeout_err), et);
                chk("last_argmax", 32'(last_argmax), el);
                if (ev >= 0) chk("vec_idx", 32'(vec_idx), ev);
                if (done) done_seen++;
            end
            chk("core_key_n", 32'(core_key_n), ek);
            chk("busy", 32'(busy), eb);
            chk("done", 32'(done), ed);
        end
    end

    // Runs one start-to-FIN pass; stray_at > 0 pulses start again while busy
    task automatic run_vectors(input int stray_at);
        plan_run();
        @(posedge clk); #1;
        start      = 1'b1;
        s_cyc      = cyc + 1;
        done_seen  = 0;
        run_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int g = 0; g < total + 4; g++) begin
            @(posedge clk); #1;
            start = (stray_at > 0 && cyc - s_cyc == stray_at);
        end
        start      = 1'b0;
        run_active = 1'b0;
        chk("done_pulses", done_seen, 1);
        chk("count_sum", 32'(pass_count) + 32'(fail_count), NV);
        for (int j = 0; j < NV; j++) if (!is_tmo[j]) prev_last = am[j];
    endtask

    task automatic fill_tie(input int l0, input int l1, input int l2, input int l3);
        for (int j = 0; j < NV; j++) begin
            for (int k = 0; k < NC; k++) prob_rom[j][k] = '0;
            prob_rom[j][0] = 16'd5;
            prob_rom[j][1] = 16'd9;
            prob_rom[j][2] = 16'd9;
            prob_rom[j][3] = 16'd2;
            delay[j] = 30;
        end
        label_rom[0] = l0; label_rom[1] = l1; label_rom[2] = l2; label_rom[3] = l3;
    endtask

    task automatic fill_random(input bit allow_tmo);
        int mode;
        for (int j = 0; j < NV; j++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < NC; k++) begin
                if (mode == 0)      prob_rom[j][k] = PW'($urandom_range(0, 3));
                else if (mode == 1) prob_rom[j][k] = PW'($urandom_range(16'hFFF0, 16'hFFFF));
                else                prob_rom[j][k] = PW'($urandom);
            end
            label_rom[j] = ($urandom_range(0, 1) == 1) ? model_argmax(j) : int'($urandom_range(0, NC - 1));
            delay[j]     = allow_tmo ? int'($urandom_range(1, 110)) : int'($urandom_range(1, 60));
        end
    endtask

    initial begin
        fill_tie(1, 1, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_key_n", 32'(core_key_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass_count), 0);
        chk("rst_fail", 32'(fail_count), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_last_argmax", 32'(last_argmax), 0);
        rst = 1'b0;

        // Reset in the middle of the key pulse
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pulse_key_low", 32'(core_key_n), 0);
        chk("pulse_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_core_key_n", 32'(core_key_n), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_counts", 32'(pass_count) + 32'(fail_count), 0);
        @(posedge clk); #1 rst = 1'b0;
        prev_last = 0;
        check_en  = 1'b1;

        // All vectors match, done 30 cycles after the pulse, extra start while busy
        for (int j = 0; j < NV; j++) begin
            for (int k = 0; k < NC; k++) prob_rom[j][k] = PW'($urandom_range(0, 1000));
            prob_rom[j][(j * 3) % NC] = 16'd2000 + PW'(j);
            label_rom[j] = (j * 3) % NC;
            delay[j]     = 30;
        end
        run_vectors(60);
        chk("all_match_pass", 32'(pass_count), 4);
        chk("all_match_fail", 32'(fail_count), 0);
        chk("all_match_last", 32'(last_argmax), 9);

        // Tie between classes 1 and 2 resolves to 1
        fill_tie(1, 2, 1, 2);
        chk("model_tie_pin", model_argmax(0), 1);
        run_vectors(0);
        chk("tie_last_argmax", 32'(last_argmax), 1);
        chk("tie_pass", 32'(pass_count), 2);
        chk("tie_fail", 32'(fail_count), 2);

        // Core never finishes: every vector times out
        for (int j = 0; j < NV; j++) delay[j] = 1000;
        run_vectors(0);
        chk("tmo_fail", 32'(fail_count), 4);
        chk("tmo_pass", 32'(pass_count), 0);
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_last_held", 32'(last_argmax), 1);

        // Full-width unsigned compare, plus done exactly at the timeout boundary
        for (int j = 0; j < NV; j++) begin
            for (int k = 0; k < NC; k++) prob_rom[j][k] = 16'h7FFF;
            prob_rom[j][9] = 16'hFFFF;
            label_rom[j]   = 9;
        end
        delay[0] = 100; delay[1] = 101; delay[2] = 1; delay[3] = 50;
        chk("model_wide_pin", model_argmax(0), 9);
        run_vectors(0);
        chk("wide_last_argmax", 32'(last_argmax), 9);
        chk("wide_pass", 32'(pass_count), 3);
        chk("wide_fail", 32'(fail_count), 1);
        chk("wide_tmo_err", 32'(timeout_err), 1);

        // Randomised runs
        for (int n = 0; n < 8; n++) begin
            fill_random(n % 2 == 1);
            run_vectors((n % 3 == 0) ? 25 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
